logic_unit_scheduler: RTL and testbench

- Shares one bitwise logic unit between two requesters. The unit performs AND, OR, NOT and NOR, built from the team's NOR-based gate modules.
- Arbitrates with round-robin priority and latches the winner's operands. It then sequences one evaluation and holds the tagged result until the consumer accepts it.
- Sits between the lab's operand sources and the shared gate datapath. Only one operation is in flight at a time.

---
 rtl/logic_unit_scheduler.sv | 156 +++++++++++++++
 tb/tb_logic_unit_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_scheduler.sv
// Round-robin scheduler that shares one NOR-built bitwise logic unit between two
// requesters and holds each tagged result until the consumer accepts it.

module nor_gate #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);
  assign y_o = ~(a_i | b_i);
endmodule

// AND/OR/NOT/NOR, with every function built from NOR gates only.
module nor_logic_unit #(
  parameter int WIDTH = 4
) (
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);
  logic [WIDTH-1:0] not_a, not_b, nor_ab, or_ab, and_ab;

  nor_gate #(.WIDTH(WIDTH)) u_not_a (.a_i(a_i),    .b_i(a_i),    .y_o(not_a));
  nor_gate #(.WIDTH(WIDTH)) u_not_b (.a_i(b_i),    .b_i(b_i),    .y_o(not_b));
  nor_gate #(.WIDTH(WIDTH)) u_nor   (.a_i(a_i),    .b_i(b_i),    .y_o(nor_ab));
  nor_gate #(.WIDTH(WIDTH)) u_or    (.a_i(nor_ab), .b_i(nor_ab), .y_o(or_ab));
  nor_gate #(.WIDTH(WIDTH)) u_and   (.a_i(not_a),  .b_i(not_b),  .y_o(and_ab));

  always_comb begin
    y_o = and_ab;
    case (op_i)
      2'b00:   y_o = and_ab;
      2'b01:   y_o = or_ab;
      2'b10:   y_o = not_a;
      default: y_o = nor_ab;
    endcase
  end
endmodule

module logic_unit_scheduler #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_inA,
  input  logic [WIDTH-1:0] req0_inB,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_inA,
  input  logic [WIDTH-1:0] req1_inB,
  output logic             req1_ready,
  output logic             out_valid,
  output logic             out_id,
  output logic [WIDTH-1:0] out_result,
  input  logic             out_ready,
  output logic             busy,
  output logic [1:0]       dbg_state
);
  // Handshakes: a request transfers on the cycle reqX_valid & reqX_ready are both
  // high; a result transfers when out_valid & out_ready are both high.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             oid_q, oid_d;
  logic             grant;
  logic [WIDTH-1:0] unit_y;

  nor_logic_unit #(.WIDTH(WIDTH)) u_unit (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .y_o  (unit_y)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      prio_q  <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      res_q   <= '0;
      oid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      res_q   <= res_d;
      oid_q   <= oid_d;
    end
  end

  // A lone valid requester wins outright; prio only breaks ties.
  assign grant = (req0_valid && req1_valid) ? prio_q : req1_valid;

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    res_d      = res_q;
    oid_d      = oid_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        req0_ready = req0_valid && !grant;
        req1_ready = req1_valid && grant;
        if (req0_ready || req1_ready) begin
          op_d    = grant ? req1_op  : req0_op;
          a_d     = grant ? req1_inA : req0_inA;
          b_d     = grant ? req1_inB : req0_inB;
          id_d    = grant;
          prio_d  = !grant;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d   = unit_y;
        oid_d   = id_q;
        state_d = S_RESULT;
      end
      S_RESULT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out_valid  = (state_q == S_RESULT);
  assign out_id     = oid_q;
  assign out_result = res_q;
  assign busy       = (state_q != S_IDLE);
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_logic_unit_scheduler.sv
// Directed plus randomized checks of logic_unit_scheduler against a
// transaction-level model of arbitration, latency and the logic functions.

module tb_logic_unit_scheduler;
  localparam int W = 4;

  logic         clk;
  logic         reset_n;
  logic         req0_valid, req1_valid;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] req0_inA, req0_inB, req1_inA, req1_inB;
  logic         req0_ready, req1_ready;
  logic         out_valid, out_id, out_ready, busy;
  logic [W-1:0] out_result;
  logic [1:0]   dbg_state;

  int checks = 0;
  int passed = 0;
  int failed = 0;
  logic exp_prio = 1'b0;
  logic [W-1:0] exp_q[$];

  logic_unit_scheduler #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_op    (req0_op),
    .req0_inA   (req0_inA),
    .req0_inB   (req0_inB),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_op    (req1_op),
    .req1_inA   (req1_inA),
    .req1_inB   (req1_inB),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_id     (out_id),
    .out_result (out_result),
    .out_ready  (out_ready),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] ref_fn(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return ~a;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered and left at edge+2 with the block idle.
  task automatic txn(input logic v0, input logic v1,
                     input logic [1:0] op0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                     input logic [1:0] op1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                     input logic wv0, input logic wv1, input int k,
                     output logic o_id, output logic [W-1:0] o_res);
    logic g;
    logic [W-1:0] er;
    req0_valid = v0; req0_op = op0; req0_inA = a0; req0_inB = b0;
    req1_valid = v1; req1_op = op1; req1_inA = a1; req1_inB = b1;
    out_ready  = 1'($urandom_range(0, 1));
    g  = (v0 && v1) ? exp_prio : v1;
    exp_q.push_back(ref_fn(g ? op1 : op0, g ? a1 : a0, g ? b1 : b0));
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_out_valid", out_valid, 0);
    chk("grant_ready0", req0_ready, v0 && !g);
    chk("grant_ready1", req1_ready, v1 && g);
    @(posedge clk);
    exp_prio = !g;
    #1;
    req0_valid = wv0; req1_valid = wv1;
    out_ready  = 1'($urandom_range(0, 1));
    #1;
    chk("exec_busy", busy, 1);
    chk("exec_out_valid", out_valid, 0);
    chk("exec_ready0", req0_ready, 0);
    chk("exec_ready1", req1_ready, 0);
    @(posedge clk);
    #1;
    out_ready = (k == 0);
    er = exp_q.pop_front();
    #1;
    chk("res_valid", out_valid, 1);
    chk("res_id", out_id, g);
    chk("res_value", out_result, er);
    o_id = out_id;
    o_res = out_result;
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
      if (i == k - 1) out_ready = 1'b1;
      #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_id", out_id, g);
      chk("hold_value", out_result, er);
      chk("hold_ready0", req0_ready, 0);
      chk("hold_ready1", req1_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'($urandom_range(0, 1));
    #1;
    chk("done_valid", out_valid, 0);
    chk("done_busy", busy, 0);
    chk("done_keep_value", out_result, er);
  endtask

  task automatic idle_cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    out_ready  = 1'($urandom_range(0, 1));
    #1;
    chk("noreq_ready0", req0_ready, 0);
    chk("noreq_ready1", req1_ready, 0);
    chk("noreq_busy", busy, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic o_id;
    logic [W-1:0] o_res;
    reset_n = 1'b0;
    req0_valid = 0; req0_op = 0; req0_inA = 0; req0_inB = 0;
    req1_valid = 0; req1_op = 0; req1_inA = 0; req1_inB = 0;
    out_ready = 0;

    // reset then idle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    reset_n = 1'b1;
    exp_prio = 1'b0;
    @(posedge clk);
    #1;
    idle_cycle();

    // single op latency, AND
    txn(1, 0, 2'b00, 4'b1100, 4'b1010, 2'b00, 0, 0, 0, 0, 0, o_id, o_res);
    chk("and_literal", o_res, 4'b1000);
    chk("and_id_literal", o_id, 0);

    // op coverage on req1
    txn(0, 1, 0, 0, 0, 2'b01, 4'b1100, 4'b1010, 0, 0, 0, o_id, o_res);
    chk("or_literal", o_res, 4'b1110);
    txn(0, 1, 0, 0, 0, 2'b10, 4'b1100, 4'b1010, 0, 0, 0, o_id, o_res);
    chk("not_literal", o_res, 4'b0011);
    txn(0, 1, 0, 0, 0, 2'b10, 4'b1100, 4'b1111, 0, 0, 1, o_id, o_res);
    chk("not_ignores_b", o_res, 4'b0011);
    txn(0, 1, 0, 0, 0, 2'b11, 4'b1100, 4'b1010, 0, 0, 0, o_id, o_res);
    chk("nor_literal", o_res, 4'b0001);
    chk("nor_id_literal", o_id, 1);

    // round robin with both valid continuously; prio is 0 after req1's grant
    for (int i = 0; i < 4; i++) begin
      txn(1, 1, 2'b01, 4'(i), 4'b0101, 2'b00, 4'(i), 4'b1111, 1, 1, 0, o_id, o_res);
      chk("rr_id_literal", o_id, i % 2);
    end

    // backpressure with req1 waiting
    txn(1, 0, 2'b11, 4'b0011, 4'b0100, 0, 4'b1001, 4'b0110, 0, 1, 5, o_id, o_res);
    chk("bp_value_literal", o_res, 4'b1000);
    txn(0, 1, 0, 0, 0, 2'b00, 4'b1001, 4'b0110, 0, 0, 0, o_id, o_res);
    chk("bp_req1_literal", o_res, 4'b0000);

    // reset during EXEC after a req0 grant
    req0_valid = 1; req0_op = 2'b01; req0_inA = 4'b1111; req0_inB = 4'b0000;
    req1_valid = 0;
    #1;
    chk("mid_ready0", req0_ready, 1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    req0_valid = 0;
    #1;
    chk("mid_exec_busy", busy, 1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_prio = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_result", out_result, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("mid_no_ghost", out_valid, 0);
    end
    #1;
    txn(1, 1, 2'b00, 4'b0110, 4'b0011, 2'b01, 4'b0001, 4'b0001, 0, 0, 0, o_id, o_res);
    chk("mid_prio_id", o_id, 0);
    chk("mid_prio_value", o_res, 4'b0010);

    // randomized transactions
    for (int n = 0; n < 40; n++) begin
      int vv;
      vv = $urandom_range(1, 3);
      if ($urandom_range(0, 4) == 0) idle_cycle();
      txn(1'(vv), 1'(vv >> 1),
          2'($urandom), 4'($urandom), 4'($urandom),
          2'($urandom), 4'($urandom), 4'($urandom),
          1'($urandom), 1'($urandom), $urandom_range(0, 3), o_id, o_res);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    failed++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
